// File: rtl/aes_pkg.sv
// Shared AES helpers: FSM state type, S-box lookup, round-constant table and round count.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_STREAM = 2'd2
  } ks_state_e;

  // FIPS-197 S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic int unsigned nr_of(input int unsigned nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word_c
);

  always_comb begin
    o_word_c = '0;
    for (int b = 0; b < 4; b++) begin
      o_word_c[8*b +: 8] = sbox(i_word[8*b +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_schedule_gen.sv
// AES-128/192/256 key expansion, one word per cycle, with cached round keys
// streamed forward or reverse over a valid/ready port.
module aes_key_schedule_gen
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                reuse,
  input  logic                decrypt,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [3:0]          rk_round,
  output logic [127:0]        rk_data,
  output logic                done
);

  localparam int unsigned NK     = KEY_BITS / 32;
  localparam int unsigned NR     = nr_of(NK);
  localparam int unsigned NW     = 4 * (NR + 1);
  localparam int unsigned WIDX_W = $clog2(NW);
  localparam int unsigned RND_W  = $clog2(NR + 1);
  localparam int unsigned KPOS_W = $clog2(NK);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_schedule_gen: KEY_BITS must be 128, 192 or 256");
  end

  ks_state_e           r_state, w_state_nxt;
  logic [31:0]         r_w [NW];
  logic [WIDX_W-1:0]   r_widx, w_widx_nxt;
  logic [KPOS_W-1:0]   r_kpos, w_kpos_nxt;
  logic [3:0]          r_rcon_idx, w_rcon_idx_nxt;
  logic [RND_W-1:0]    r_round, w_round_nxt, w_round_step, w_rd_round;
  logic                r_cache_valid, w_cache_nxt;
  logic                r_decrypt, w_dec_nxt;
  logic                r_ld, w_ld_nxt;
  logic                w_valid_nxt, w_done_nxt;
  logic [127:0]        w_data_nxt, w_rk_rd;
  logic                w_key_load, w_word_we, w_last;
  logic [31:0]         w_prev, w_back, w_sub_in, w_sub, w_t, w_new;
  logic [WIDX_W-1:0]   w_base;

  // Expansion datapath: w[i] = w[i-NK] ^ f(w[i-1])
  assign w_prev   = r_w[WIDX_W'(r_widx - WIDX_W'(1))];
  assign w_back   = r_w[WIDX_W'(r_widx - WIDX_W'(NK))];
  assign w_sub_in = (r_kpos == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .i_word   (w_sub_in),
    .o_word_c (w_sub)
  );

  always_comb begin
    w_t = w_prev;
    if (r_kpos == '0) begin
      w_t = w_sub ^ {rcon(r_rcon_idx), 24'h0};
    end else if (NK == 8 && r_kpos == KPOS_W'(4)) begin
      w_t = w_sub;
    end
  end

  assign w_new = w_back ^ w_t;

  // Round-key read: current round when (re)loading, otherwise the round after a handshake
  assign w_round_step = r_decrypt ? RND_W'(r_round - RND_W'(1)) : RND_W'(r_round + RND_W'(1));
  assign w_rd_round   = r_ld ? r_round : w_round_step;
  assign w_base       = WIDX_W'({w_rd_round, 2'b00});
  assign w_rk_rd      = {r_w[w_base], r_w[WIDX_W'(w_base + WIDX_W'(1))],
                         r_w[WIDX_W'(w_base + WIDX_W'(2))], r_w[WIDX_W'(w_base + WIDX_W'(3))]};
  assign w_last       = r_decrypt ? (r_round == '0) : (r_round == RND_W'(NR));
  assign rk_round     = 4'(r_round);

  always_comb begin
    w_state_nxt    = r_state;
    w_widx_nxt     = r_widx;
    w_kpos_nxt     = r_kpos;
    w_rcon_idx_nxt = r_rcon_idx;
    w_round_nxt    = r_round;
    w_cache_nxt    = r_cache_valid;
    w_dec_nxt      = r_decrypt;
    w_ld_nxt       = 1'b0;
    w_valid_nxt    = rk_valid;
    w_data_nxt     = rk_data;
    w_done_nxt     = 1'b0;
    w_key_load     = 1'b0;
    w_word_we      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_dec_nxt   = decrypt;
          w_round_nxt = decrypt ? RND_W'(NR) : '0;
          if (reuse && r_cache_valid) begin
            w_state_nxt = ST_STREAM;
          end else begin
            w_key_load     = 1'b1;
            w_widx_nxt     = WIDX_W'(NK);
            w_kpos_nxt     = '0;
            w_rcon_idx_nxt = 4'd1;
            w_cache_nxt    = 1'b0;
            w_state_nxt    = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        w_word_we = 1'b1;
        if (r_widx == WIDX_W'(NW - 1)) begin
          w_cache_nxt = 1'b1;
          w_ld_nxt    = 1'b1;
          w_state_nxt = ST_STREAM;
        end else begin
          w_widx_nxt = WIDX_W'(r_widx + WIDX_W'(1));
          if (r_kpos == KPOS_W'(NK - 1)) begin
            w_kpos_nxt     = '0;
            w_rcon_idx_nxt = 4'(r_rcon_idx + 4'd1);
          end else begin
            w_kpos_nxt = KPOS_W'(r_kpos + KPOS_W'(1));
          end
        end
      end
      ST_STREAM: begin
        if (r_ld) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_rk_rd;
        end else if (rk_valid) begin
          if (rk_ready) begin
            if (w_last) begin
              w_valid_nxt = 1'b0;
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_round_nxt = w_round_step;
              w_data_nxt  = w_rk_rd;
            end
          end
        end else begin
          // Replay entry spends one cycle arming the first read
          w_ld_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_widx        <= '0;
      r_kpos        <= '0;
      r_rcon_idx    <= '0;
      r_round       <= '0;
      r_cache_valid <= 1'b0;
      r_decrypt     <= 1'b0;
      r_ld          <= 1'b0;
      busy          <= 1'b0;
      rk_valid      <= 1'b0;
      rk_data       <= '0;
      done          <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_widx        <= w_widx_nxt;
      r_kpos        <= w_kpos_nxt;
      r_rcon_idx    <= w_rcon_idx_nxt;
      r_round       <= w_round_nxt;
      r_cache_valid <= w_cache_nxt;
      r_decrypt     <= w_dec_nxt;
      r_ld          <= w_ld_nxt;
      busy          <= (w_state_nxt != ST_IDLE);
      rk_valid      <= w_valid_nxt;
      rk_data       <= w_data_nxt;
      done          <= w_done_nxt;
    end
  end

  // Word store keeps its contents across reset
  always_ff @(posedge clk) begin
    if (w_key_load) begin
      for (int k = 0; k < NK; k++) begin
        r_w[k] <= key_in[32*(NK-1-k) +: 32];
      end
    end else if (w_word_we) begin
      r_w[r_widx] <= w_new;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_gen.sv
// Scoreboard bench for aes_key_schedule_gen: AES-128/192/256 instances against a
// FIPS-197 reference whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_schedule_gen;

  typedef struct packed {
    logic [1:0]   inst;
    logic [3:0]   round;
    logic [127:0] data;
    logic         last;
  } exp_t;

  localparam logic [255:0] KEY_STD =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic              clk, rst;
  logic [2:0]        start_s, reuse_s, decrypt_s, ready_s;
  logic [2:0]        busy_s, valid_s, done_s;
  logic [2:0][3:0]   round_s;
  logic [2:0][127:0] data_s;
  logic [255:0]      key_s;
  logic [2:0]        rand_ready;

  int           n_checks, n_fail;
  exp_t         exp_q[$];
  int           hs_cnt [3];
  logic [127:0] cap [3][16];
  logic [7:0]   sbox_ref [256];
  logic [31:0]  ref_w [60];
  logic         done_pend [3];
  logic         stall_prev [3];
  logic [127:0] stall_data [3];
  logic [3:0]   stall_round [3];

  aes_key_schedule_gen #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .start(start_s[0]), .reuse(reuse_s[0]), .decrypt(decrypt_s[0]),
    .key_in(key_s[255 -: 128]), .busy(busy_s[0]), .rk_valid(valid_s[0]), .rk_ready(ready_s[0]),
    .rk_round(round_s[0]), .rk_data(data_s[0]), .done(done_s[0]));

  aes_key_schedule_gen #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst(rst), .start(start_s[1]), .reuse(reuse_s[1]), .decrypt(decrypt_s[1]),
    .key_in(key_s[255 -: 192]), .busy(busy_s[1]), .rk_valid(valid_s[1]), .rk_ready(ready_s[1]),
    .rk_round(round_s[1]), .rk_data(data_s[1]), .done(done_s[1]));

  aes_key_schedule_gen #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .start(start_s[2]), .reuse(reuse_s[2]), .decrypt(decrypt_s[2]),
    .key_in(key_s), .busy(busy_s[2]), .rk_valid(valid_s[2]), .rk_ready(ready_s[2]),
    .rk_round(round_s[2]), .rk_data(data_s[2]), .done(done_s[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(b));
      x = inv;
      sbox_ref[b] = x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_ref(input logic [31:0] x);
    return {sbox_ref[x[31:24]], sbox_ref[x[23:16]], sbox_ref[x[15:8]], sbox_ref[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_ref(input int j);
    logic [7:0] x;
    x = 8'h01;
    for (int k = 1; k < j; k++) x = gf_mul(x, 8'h02);
    return x;
  endfunction

  task automatic ref_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) ref_w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0)
        t = sub_word_ref({t[23:0], t[31:24]}) ^ {rcon_ref(i / nk), 24'h0};
      else if (nk == 8 && i % nk == 4)
        t = sub_word_ref(t);
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // ---------------- ready driver ----------------
  initial begin
    ready_s = 3'b111;
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++)
        ready_s[g] = rand_ready[g] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      done_pend[g] = 1'b0; stall_prev[g] = 1'b0; hs_cnt[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (done_pend[g] || done_s[g])
          check($sformatf("done_pulse%0d", g), 128'(done_s[g]), 128'(done_pend[g]));
        done_pend[g] = 1'b0;
        if (stall_prev[g]) begin
          check($sformatf("stall_valid%0d", g), 128'(valid_s[g]), 128'd1);
          check($sformatf("stall_data%0d", g), data_s[g], stall_data[g]);
          check($sformatf("stall_round%0d", g), 128'(round_s[g]), 128'(stall_round[g]));
        end
        stall_prev[g]  = valid_s[g] && !ready_s[g];
        stall_data[g]  = data_s[g];
        stall_round[g] = round_s[g];
        if (valid_s[g] && ready_s[g]) begin
          hs_cnt[g]++;
          cap[g][round_s[g]] = data_s[g];
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_rk%0d: got round %0d expected no handshake", g, round_s[g]);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("rk_inst%0d", g), 128'(g), 128'(e.inst));
            check($sformatf("rk_round%0d", g), 128'(round_s[g]), 128'(e.round));
            check($sformatf("rk_data%0d_r%0d", g, e.round), data_s[g], e.data);
            if (e.last) done_pend[g] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle in which done is high.
  task automatic run_job(input int g, input logic [255:0] key, input logic dec, input logic reu,
                         input int exp_lat, input int inj, input string tag);
    int nk, nr, n, cyc, r;
    logic seen;
    exp_t e;
    nk = 4 + 2 * g;
    nr = nk + 6;
    ref_expand(key, nk);
    hs_cnt[g] = 0;
    for (int k = 0; k < 16; k++) cap[g][k] = '0;
    for (int k = 0; k <= nr; k++) begin
      r = dec ? nr - k : k;
      e.inst  = 2'(g);
      e.round = 4'(r);
      e.data  = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
      e.last  = (k == nr);
      exp_q.push_back(e);
    end
    key_s = key; decrypt_s[g] = dec; reuse_s[g] = reu; start_s[g] = 1'b1;
    @(posedge clk);
    #1;
    start_s[g] = 1'b0; reuse_s[g] = 1'b0; decrypt_s[g] = ~dec; key_s = rand_key();
    n = 0;
    while (!valid_s[g] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(exp_lat));
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 2000) begin
      if (inj > 0 && cyc == inj) begin
        start_s[g] = 1'b1; reuse_s[g] = 1'b0; decrypt_s[g] = 1'b1; key_s = rand_key();
      end else begin
        start_s[g] = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done_s[g]) seen = 1'b1;
    end
    start_s[g] = 1'b0;
    check({tag, "_done_seen"}, 128'(seen), 128'd1);
    check({tag, "_handshakes"}, 128'(hs_cnt[g]), 128'(nr + 1));
    check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    logic [255:0] k4, k6;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start_s = '0; reuse_s = '0; decrypt_s = '0; key_s = '0; rand_ready = '0;
    build_sbox();
    idle(3);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_busy%0d", g), 128'(busy_s[g]), 128'd0);
      check($sformatf("reset_valid%0d", g), 128'(valid_s[g]), 128'd0);
      check($sformatf("reset_done%0d", g), 128'(done_s[g]), 128'd0);
      check($sformatf("reset_round%0d", g), 128'(round_s[g]), 128'd0);
      check($sformatf("reset_data%0d", g), data_s[g], 128'd0);
    end
    rst = 1'b0;
    idle(2);

    // AES-128 known answer, encrypt
    run_job(0, KEY_STD, 1'b0, 1'b0, 41, 0, "t1");
    check("t1_round1", cap[0][1], 128'hD6AA74FD_D2AF72FA_DAA678F1_D6AB76FE);
    check("t1_round10", cap[0][10], 128'h13111D7F_E3944A17_F307A78B_4D2B30C5);
    idle(5);

    // Replay with a start injected mid-stream
    run_job(0, KEY_STD, 1'b0, 1'b1, 2, 3, "t5");
    check("t5_round0", cap[0][0], 128'h00010203_04050607_08090A0B_0C0D0E0F);
    idle(60);
    check("t5_idle_busy", 128'(busy_s[0]), 128'd0);

    // AES-192 (reuse requested with no cached schedule) and AES-256 known answers
    run_job(1, KEY_STD, 1'b0, 1'b1, 47, 0, "t2");
    check("t2_round12", cap[1][12], 128'hA4970A33_1A78DC09_C418C271_E3A41D5D);
    idle(2);
    run_job(2, KEY_STD, 1'b0, 1'b0, 53, 0, "t3");
    check("t3_round14", cap[2][14], 128'h24FC79CC_BF0979E9_371AC23C_6D68DE36);
    idle(2);

    // Decrypt order with random backpressure, then a replay started while done is high
    rand_ready = 3'b111;
    k4 = rand_key();
    run_job(0, k4, 1'b1, 1'b0, 41, 0, "t4_dec");
    run_job(0, k4, 1'b0, 1'b1, 2, 0, "t4_replay");
    idle(2);
    for (int j = 0; j < 3; j++) begin
      k4 = rand_key();
      run_job(1, k4, 1'($urandom_range(0, 1)), 1'b0, 47, 0, "rnd192");
      run_job(1, k4, 1'($urandom_range(0, 1)), 1'b1, 2, 0, "rnd192_replay");
      run_job(2, k4, 1'($urandom_range(0, 1)), 1'b0, 53, 0, "rnd256");
      idle(1);
    end
    rand_ready = '0;
    idle(3);

    // Reset in the middle of an expansion invalidates the cache
    key_s = rand_key(); reuse_s[0] = 1'b0; decrypt_s[0] = 1'b0; start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    idle(10);
    check("t6_busy_before", 128'(busy_s[0]), 128'd1);
    rst = 1'b1;
    #1;
    check("t6_busy_rst", 128'(busy_s[0]), 128'd0);
    check("t6_valid_rst", 128'(valid_s[0]), 128'd0);
    idle(1);
    rst = 1'b0;
    idle(1);
    k6 = rand_key();
    run_job(0, k6, 1'b0, 1'b1, 41, 0, "t6");
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
